serial_frame_tx: RTL and testbench



---
 rtl/serial_frame_tx.sv | 141 ++++++++++++++
 tb/tb_serial_frame_tx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, data LSB first, optional
// even parity, stop bit. Every output comes straight from a flop, so the
// receiver's sampling chain always sees a glitch-free line.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy
);

    localparam int CYC_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_q, par_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                last_cyc;

    assign last_cyc  = (cyc_q == CYC_W'(CLKS_PER_BIT - 1));
    assign tx_out    = tx_q;
    assign busy      = busy_q;
    assign ready_out = ready_q;

    // Next-state, counters and shifter; outputs are derived from the next
    // state so the registered line changes on the same edge as the state.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;

        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    shift_d = data_in;
                    par_d   = ^data_in;
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (last_cyc) begin
                    cyc_d   = '0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_DATA: begin
                if (last_cyc) begin
                    cyc_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_PARITY: begin
                if (last_cyc) begin
                    cyc_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            S_STOP: begin
                if (last_cyc) begin
                    cyc_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            default: begin
                cyc_d   = '0;
                bit_d   = '0;
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three instances (parity 4 clk/bit, no parity
// 4 clk/bit, parity 1 clk/bit). A per-instance queue holds the expected
// {tx_out, busy, ready_out} for every cycle of each frame; acceptance is
// predicted by the bench's own model (model idle + valid).
module tb_serial_frame_tx;

    logic       clk;
    logic       rst;
    logic       valid [3];
    logic [7:0] din   [3];
    logic       tx    [3];
    logic       busy  [3];
    logic       ready [3];

    int errors;
    int checks;
    bit mon_en;

    logic [2:0] sbq [3][$];

    typedef struct {
        int         k;
        logic [7:0] data;
        logic       par;
    } vec_t;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut0 (
        .clk(clk), .rst(rst), .data_in(din[0]), .valid_in(valid[0]),
        .ready_out(ready[0]), .tx_out(tx[0]), .busy(busy[0]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .valid_in(valid[1]),
        .ready_out(ready[1]), .tx_out(tx[1]), .busy(busy[1]));

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1)) dut2 (
        .clk(clk), .rst(rst), .data_in(din[2]), .valid_in(valid[2]),
        .ready_out(ready[2]), .tx_out(tx[2]), .busy(busy[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-cycle scoreboard compare; empty queue means the line must be idle.
    always @(negedge clk) begin : mon
        logic [2:0] e;
        logic [2:0] a;
        if (mon_en) begin
            for (int k = 0; k < 3; k++) begin
                if (sbq[k].size() > 0) e = sbq[k].pop_front();
                else                   e = 3'b101;
                a = {tx[k], busy[k], ready[k]};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL mon dut%0d t=%0t tx/busy/ready got=%b want=%b",
                             k, $time, a, e);
                end
            end
        end
    end

    task automatic push_frame(input int k, input logic [7:0] d, input logic p);
        int cpb;
        bit pen;
        cpb = (k == 2) ? 1 : 4;
        pen = (k != 1);
        for (int c = 0; c < cpb; c++) sbq[k].push_back(3'b010);
        for (int i = 0; i < 8; i++)
            for (int c = 0; c < cpb; c++) sbq[k].push_back({d[i], 2'b10});
        if (pen)
            for (int c = 0; c < cpb; c++) sbq[k].push_back({p, 2'b10});
        for (int c = 0; c < cpb; c++) sbq[k].push_back(3'b110);
        sbq[k].push_back(3'b101);
    endtask

    // Present a word; it is accepted on the first edge the model is idle.
    task automatic send(input int k, input logic [7:0] d, input logic p, input bit hold);
        int n;
        din[k]   = d;
        valid[k] = 1'b1;
        n = 0;
        while (sbq[k].size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sbq[k].size() != 0) begin
            errors++;
            checks++;
            $display("FAIL send_timeout dut%0d queue=%0d want=0", k, sbq[k].size());
        end
        @(posedge clk);
        push_frame(k, d, p);
        #1;
        if (!hold) valid[k] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0) begin
            errors++;
            $display("FAIL idle_timeout pending=%0d want=0",
                     sbq[0].size() + sbq[1].size() + sbq[2].size());
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic chk_idle_now(input string name);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({tx[k], busy[k], ready[k]} !== 3'b101) begin
                errors++;
                $display("FAIL %s dut%0d tx/busy/ready got=%b want=101",
                         name, k, {tx[k], busy[k], ready[k]});
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t want finish earlier", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{0, 8'hA5, 1'b0};
        vecs[1] = '{0, 8'h07, 1'b1};
        vecs[2] = '{1, 8'h07, 1'b0};
        vecs[3] = '{2, 8'hA5, 1'b0};
        vecs[4] = '{0, 8'h00, 1'b0};
        vecs[5] = '{0, 8'hFF, 1'b0};
        vecs[6] = '{2, 8'h07, 1'b1};
        vecs[7] = '{1, 8'hA5, 1'b0};

        errors = 0;
        checks = 0;
        mon_en = 1'b0;
        rst    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            valid[k] = 1'b0;
            din[k]   = 8'h00;
        end

        // Reset asserted between edges must take effect without a clock.
        #2;
        rst = 1'b1;
        #1;
        chk_idle_now("reset_async");
        mon_en = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send(vecs[i].k, vecs[i].data, vecs[i].par, 1'b0);
            wait_idle();
        end

        // Back-to-back with valid held: one idle cycle between frames.
        send(0, 8'h3C, 1'b0, 1'b1);
        send(0, 8'hC3, 1'b0, 1'b0);
        wait_idle();

        // Busy-time valid pulse with different data must be ignored.
        send(0, 8'h5A, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        din[0]   = 8'h00;
        valid[0] = 1'b1;
        @(negedge clk);
        #1;
        valid[0] = 1'b0;
        din[0]   = 8'hFF;
        wait_idle();

        // Reset during data bit 3 of 0xFF, valid high through reset.
        send(0, 8'hFF, 1'b0, 1'b0);
        repeat (18) @(negedge clk);
        #2;
        for (int k = 0; k < 3; k++) sbq[k].delete();
        din[0]   = 8'h55;
        valid[0] = 1'b1;
        rst      = 1'b1;
        #1;
        chk_idle_now("reset_midframe");
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        send(0, 8'h81, 1'b0, 1'b0);
        wait_idle();

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
